// File: rtl/tp_crosspoint_seq_if.sv
// Sequencer request and table-load bundle for tp_crosspoint_seq.
// master drives requests and table writes; slave returns the acks.
interface tp_crosspoint_seq_if #(
  parameter int N_TP  = 12,
  parameter int N_CP  = 16,
  parameter int SUB_W = 4
);
  localparam int TP_W = $clog2(N_TP);

  logic             PINC_REQ;
  logic             PINC_ACK;
  logic [SUB_W-1:0] SQ;
  logic             SQ_VLD;
  logic             NISQ;
  logic             TBL_WE;
  logic [SUB_W-1:0] TBL_SQ;
  logic [TP_W-1:0]  TBL_TP;
  logic [N_CP-1:0]  TBL_D;

  modport master (
    output PINC_REQ,
    output SQ,
    output SQ_VLD,
    output TBL_WE,
    output TBL_SQ,
    output TBL_TP,
    output TBL_D,
    input  PINC_ACK,
    input  NISQ
  );

  modport slave (
    input  PINC_REQ,
    input  SQ,
    input  SQ_VLD,
    input  TBL_WE,
    input  TBL_SQ,
    input  TBL_TP,
    input  TBL_D,
    output PINC_ACK,
    output NISQ
  );
endinterface

// File: rtl/tp_crosspoint_seq.sv
// Timepulse ring plus table-driven crosspoint decode.
// Codes are latched at MCT boundaries: GOJAM > PINC > SQ > NOP.
module tp_crosspoint_seq #(
  parameter int N_TP       = 12,
  parameter int N_CP       = 16,
  parameter int SUB_W      = 4,
  parameter int NOP_CODE   = 0,
  parameter int PINC_CODE  = 14,
  parameter int GOJAM_CODE = 15
) (
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                RUN,
  input  logic                GOJAM,
  tp_crosspoint_seq_if.slave  bus,
  output logic [N_TP-1:0]     TP,
  output logic [SUB_W-1:0]    CUR_SQ,
  output logic [N_CP-1:0]     CP_,
  output logic                BUSY
);
  localparam int TP_W = $clog2(N_TP);
  localparam int ROWS = 2 ** SUB_W;
  localparam logic [TP_W-1:0] TP_LAST = TP_W'(N_TP - 1);
  localparam logic [SUB_W-1:0] C_NOP = SUB_W'(NOP_CODE);
  localparam logic [SUB_W-1:0] C_PINC = SUB_W'(PINC_CODE);
  localparam logic [SUB_W-1:0] C_GJ = SUB_W'(GOJAM_CODE);

  typedef enum logic {
    S_HALT,
    S_RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [TP_W-1:0]  tp_q;
  logic [TP_W-1:0]  tp_d;
  logic [SUB_W-1:0] cur_q;
  logic [SUB_W-1:0] cur_d;
  logic             nisq_q;
  logic             nisq_d;
  logic             ack_q;
  logic             ack_d;

  logic [N_CP-1:0]  tbl_q [ROWS][N_TP];
  logic             tbl_wr;
  logic [N_CP-1:0]  word;

  logic [SUB_W-1:0] pick_code;
  logic             pick_sq;
  logic             pick_pinc;

  always_comb begin
    pick_code = C_NOP;
    pick_sq   = 1'b0;
    pick_pinc = 1'b0;
    priority case (1'b1)
      GOJAM: begin
        pick_code = C_GJ;
      end
      bus.PINC_REQ: begin
        pick_code = C_PINC;
        pick_pinc = 1'b1;
      end
      bus.SQ_VLD: begin
        pick_code = bus.SQ;
        pick_sq   = 1'b1;
      end
      default: begin
        pick_code = C_NOP;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    cur_d   = cur_q;
    nisq_d  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (RUN) begin
          state_d = S_RUN;
          tp_d    = '0;
          cur_d   = pick_code;
          nisq_d  = pick_sq;
          ack_d   = pick_pinc;
        end else if (GOJAM) begin
          cur_d = C_GJ;
        end
      end
      S_RUN: begin
        if (tp_q == TP_LAST) begin
          tp_d = '0;
          if (!RUN) begin
            // Halting never consumes a request; GOJAM still marks the code.
            state_d = S_HALT;
            if (GOJAM) cur_d = C_GJ;
          end else begin
            cur_d  = pick_code;
            nisq_d = pick_sq;
            ack_d  = pick_pinc;
          end
        end else if (GOJAM) begin
          tp_d  = '0;
          cur_d = C_GJ;
        end else begin
          tp_d = tp_q + TP_W'(1);
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign tbl_wr = (state_q == S_HALT) && bus.TBL_WE
               && (32'(bus.TBL_TP) < N_TP);

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state_q <= S_HALT;
      tp_q    <= '0;
      cur_q   <= C_NOP;
      nisq_q  <= 1'b0;
      ack_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < N_TP; c++) begin
          tbl_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      cur_q   <= cur_d;
      nisq_q  <= nisq_d;
      ack_q   <= ack_d;
      if (tbl_wr) begin
        tbl_q[bus.TBL_SQ][bus.TBL_TP] <= bus.TBL_D;
      end
    end
  end

  assign word         = tbl_q[cur_q][tp_q];
  assign BUSY         = (state_q == S_RUN);
  assign TP           = BUSY ? (N_TP'(1) << tp_q) : '0;
  assign CP_          = BUSY ? ~word : '1;
  assign CUR_SQ       = cur_q;
  assign bus.NISQ     = nisq_q;
  assign bus.PINC_ACK = ack_q;
endmodule

// File: tb/tb_tp_crosspoint_seq.sv
// Directed bench: MCT-start events checked against a queued scoreboard.
// Per-pulse and halt/reset state checked inline by the stimulus.
module tb_tp_crosspoint_seq;
  logic        CLOCK = 1'b0;
  logic        rst;
  logic        RUN;
  logic        GOJAM;
  logic [11:0] TP;
  logic [3:0]  CUR_SQ;
  logic [15:0] CP_;
  logic        BUSY;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  cur;
    logic [15:0] cp;
    logic        nisq;
    logic        ack;
  } exp_t;

  exp_t q[$];

  tp_crosspoint_seq_if bus ();

  tp_crosspoint_seq dut (
    .CLOCK  (CLOCK),
    .rst    (rst),
    .RUN    (RUN),
    .GOJAM  (GOJAM),
    .bus    (bus),
    .TP     (TP),
    .CUR_SQ (CUR_SQ),
    .CP_    (CP_),
    .BUSY   (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic walk(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(logic [3:0] c, logic [15:0] cp, logic n, logic a);
    exp_t e;
    e.cur = c;
    e.cp = cp;
    e.nisq = n;
    e.ack = a;
    q.push_back(e);
  endtask

  task automatic wr(logic [3:0] row, logic [3:0] col, logic [15:0] d);
    bus.TBL_WE = 1'b1;
    bus.TBL_SQ = row;
    bus.TBL_TP = col;
    bus.TBL_D  = d;
    tick();
    bus.TBL_WE = 1'b0;
  endtask

  // An MCT start or any ack pulse must match the next queued entry.
  always @(negedge CLOCK) begin
    if (rst && BUSY && (TP[0] || bus.NISQ || bus.PINC_ACK)) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL mct_event: unexpected TP=%h CUR_SQ=%0d NISQ=%b ACK=%b",
                 TP, CUR_SQ, bus.NISQ, bus.PINC_ACK);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_tp", 32'(TP), 32'h001);
        check("sb_cur_sq", 32'(CUR_SQ), 32'(e.cur));
        check("sb_cp", 32'(CP_), 32'(e.cp));
        check("sb_nisq", 32'(bus.NISQ), 32'(e.nisq));
        check("sb_pinc_ack", 32'(bus.PINC_ACK), 32'(e.ack));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    RUN = 1'b0;
    GOJAM = 1'b0;
    bus.PINC_REQ = 1'b0;
    bus.SQ = '0;
    bus.SQ_VLD = 1'b0;
    bus.TBL_WE = 1'b0;
    bus.TBL_SQ = '0;
    bus.TBL_TP = '0;
    bus.TBL_D = '0;
    tick();
    tick();
    check("rst_tp", 32'(TP), 32'h000);
    check("rst_cp", 32'(CP_), 32'hFFFF);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_nisq", 32'(bus.NISQ), 32'h0);
    check("rst_ack", 32'(bus.PINC_ACK), 32'h0);
    check("rst_cur", 32'(CUR_SQ), 32'h0);
    rst = 1'b1;

    wr(4'd3, 4'd0, 16'h0001);
    wr(4'd3, 4'd11, 16'h8000);
    wr(4'd14, 4'd0, 16'h0F00);
    wr(4'd15, 4'd0, 16'h00F0);
    wr(4'd5, 4'd0, 16'h1234);

    GOJAM = 1'b1;
    tick();
    GOJAM = 1'b0;
    check("halt_gojam_cur", 32'(CUR_SQ), 32'd15);
    check("halt_gojam_busy", 32'(BUSY), 32'h0);
    check("halt_gojam_tp", 32'(TP), 32'h000);

    bus.SQ = 4'd3;
    bus.SQ_VLD = 1'b1;
    RUN = 1'b1;
    push(4'd3, 16'hFFFE, 1'b1, 1'b0);
    tick();
    bus.SQ_VLD = 1'b0;
    for (int i = 1; i < 12; i++) begin
      tick();
      check("walk_tp", 32'(TP), 32'(1) << i);
      check("walk_cp", 32'(CP_), (i == 11) ? 32'h7FFF : 32'hFFFF);
    end

    bus.PINC_REQ = 1'b1;
    bus.SQ = 4'd5;
    bus.SQ_VLD = 1'b1;
    push(4'd14, 16'hF0FF, 1'b0, 1'b1);
    tick();
    bus.PINC_REQ = 1'b0;
    walk(11);
    push(4'd5, 16'hEDCB, 1'b1, 1'b0);
    tick();
    bus.SQ_VLD = 1'b0;
    tick();
    check("nisq_one_cycle", 32'(bus.NISQ), 32'h0);
    walk(4);
    check("pre_gojam_tp", 32'(TP), 32'h020);

    GOJAM = 1'b1;
    bus.SQ = 4'd3;
    bus.SQ_VLD = 1'b1;
    push(4'd15, 16'hFF0F, 1'b0, 1'b0);
    tick();
    GOJAM = 1'b0;
    walk(11);
    push(4'd3, 16'hFFFE, 1'b1, 1'b0);
    tick();
    bus.SQ_VLD = 1'b0;

    walk(2);
    check("pre_halt_tp", 32'(TP), 32'h004);
    RUN = 1'b0;
    bus.SQ = 4'd5;
    bus.SQ_VLD = 1'b1;
    wr(4'd5, 4'd0, 16'hAAAA);
    walk(8);
    check("halt_last_tp", 32'(TP), 32'h800);
    check("halt_last_cp", 32'(CP_), 32'h7FFF);
    tick();
    check("halted_tp", 32'(TP), 32'h000);
    check("halted_cp", 32'(CP_), 32'hFFFF);
    check("halted_busy", 32'(BUSY), 32'h0);
    check("halted_nisq", 32'(bus.NISQ), 32'h0);
    check("halted_cur", 32'(CUR_SQ), 32'd3);
    tick();
    check("halted_stay", 32'(BUSY), 32'h0);

    RUN = 1'b1;
    push(4'd5, 16'hEDCB, 1'b1, 1'b0);
    tick();
    bus.SQ_VLD = 1'b0;
    walk(11);
    push(4'd0, 16'hFFFF, 1'b0, 1'b0);
    tick();
    check("nop_cur", 32'(CUR_SQ), 32'd0);

    walk(6);
    check("pre_rst_tp", 32'(TP), 32'h040);
    rst = 1'b0;
    tick();
    check("midrst_tp", 32'(TP), 32'h000);
    check("midrst_cp", 32'(CP_), 32'hFFFF);
    check("midrst_busy", 32'(BUSY), 32'h0);
    check("midrst_cur", 32'(CUR_SQ), 32'd0);
    rst = 1'b1;
    bus.SQ = 4'd3;
    bus.SQ_VLD = 1'b1;
    push(4'd3, 16'hFFFF, 1'b1, 1'b0);
    tick();
    bus.SQ_VLD = 1'b0;
    RUN = 1'b0;
    walk(11);
    check("cleared_tp", 32'(TP), 32'h800);
    check("cleared_cp", 32'(CP_), 32'hFFFF);
    tick();
    check("final_busy", 32'(BUSY), 32'h0);
    walk(2);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
